// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single memory port between the instruction-fetch requester and
// the data requester. Each access holds the bus for LATENCY cycles and then
// returns a one-cycle ready pulse to the requester that owned it.
// Data has priority, but a fetch that has waited through STARVE_LIMIT
// consecutive data grants is forced through next.

module mem_port_arbiter #(
  parameter int LATENCY      = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_dout,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_din,
  output logic        d_ready,
  output logic [31:0] d_dout,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam int CntW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int StarveW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [StarveW-1:0]  starveCnt_q;
  logic                isWrite_q;
  logic                ownerData_q;
  logic [31:0]         memAddr_q;
  logic [31:0]         memDin_q;
  logic                memRead_q;
  logic                memWrite_q;
  logic                iReady_q;
  logic                dReady_q;
  logic [31:0]         iDout_q;
  logic [31:0]         dDout_q;

  logic                fetchForced;
  logic                grantData;
  logic                grantFetch;
  logic                grantStore;
  logic [StarveW-1:0]  starveCnt_d;

  // Arbitration decision for the IDLE cycle: data wins unless fetch is starving.
  always_comb begin
    fetchForced = i_req && (starveCnt_q == StarveW'(STARVE_LIMIT));
    grantData   = d_req && !fetchForced;
    grantFetch  = i_req && !grantData;
    grantStore  = grantData && d_write;
    starveCnt_d = starveCnt_q;
    if (grantData) begin
      if (!i_req) begin
        starveCnt_d = '0;
      end else if (starveCnt_q != StarveW'(STARVE_LIMIT)) begin
        starveCnt_d = starveCnt_q + StarveW'(1);
      end
    end else if (grantFetch) begin
      starveCnt_d = '0;
    end
  end

  // Main FSM: grant in IDLE, hold the bus for LATENCY cycles, then pulse ready.
  // Every output is a register so the memory sees glitch-free controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starveCnt_q <= '0;
      isWrite_q   <= 1'b0;
      ownerData_q <= 1'b0;
      memAddr_q   <= '0;
      memDin_q    <= '0;
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      iReady_q    <= 1'b0;
      dReady_q    <= 1'b0;
      iDout_q     <= '0;
      dDout_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          memRead_q  <= 1'b0;
          memWrite_q <= 1'b0;
          if (grantData || grantFetch) begin
            state_q     <= ACCESS;
            cnt_q       <= CntW'(LATENCY - 1);
            starveCnt_q <= starveCnt_d;
            ownerData_q <= grantData;
            isWrite_q   <= grantStore;
            memAddr_q   <= grantData ? d_addr : i_addr;
            memDin_q    <= grantData ? d_din : 32'd0;
            memRead_q   <= !grantStore;
            // With a one-cycle latency the first access cycle is also the last.
            memWrite_q  <= grantStore && (LATENCY == 1);
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q    <= RESP;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            if (ownerData_q) begin
              dReady_q <= 1'b1;
              if (!isWrite_q) begin
                dDout_q <= mem_dout;
              end
            end else begin
              iReady_q <= 1'b1;
              iDout_q  <= mem_dout;
            end
          end else begin
            cnt_q      <= cnt_q - CntW'(1);
            memWrite_q <= isWrite_q && (cnt_q == CntW'(1));
          end
        end
        RESP: begin
          state_q  <= IDLE;
          iReady_q <= 1'b0;
          dReady_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          memRead_q  <= 1'b0;
          memWrite_q <= 1'b0;
          iReady_q   <= 1'b0;
          dReady_q   <= 1'b0;
        end
      endcase
    end
  end

  assign i_ready   = iReady_q;
  assign i_dout    = iDout_q;
  assign d_ready   = dReady_q;
  assign d_dout    = dDout_q;
  assign mem_addr  = memAddr_q;
  assign mem_din   = memDin_q;
  assign mem_read  = memRead_q;
  assign mem_write = memWrite_q;

endmodule
